// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if: pad-side and controller-side signal bundle of the GPIO
// input conditioning stage. The driver of the raw pad levels and configuration
// uses the master modport; the filter itself uses the slave modport.
interface gpio_in_filter_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  // Raw pad levels, asynchronous to the system clock
  logic [WIDTH-1:0] pad_in_i;
  // Stability threshold in clock cycles (0 behaves as 1), quasi-static
  logic [CNT_W-1:0] thresh_i;
  // Per-pin bypass: 1 = present the synchronised level directly
  logic [WIDTH-1:0] bypass_i;
  // Conditioned levels towards the GPIO controller
  logic [WIDTH-1:0] gpio_in_o;
  // One-cycle event pulses on 0->1 / 1->0 of gpio_in_o
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;

  modport master (
    output pad_in_i,
    output thresh_i,
    output bypass_i,
    input  gpio_in_o,
    input  rise_o,
    input  fall_o
  );

  modport slave (
    input  pad_in_i,
    input  thresh_i,
    input  bypass_i,
    output gpio_in_o,
    output rise_o,
    output fall_o
  );
endinterface

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin input conditioning for the GPIO pads.
// Each pin is synchronised through SYNC_STAGES flops, then passed through a
// glitch filter that only accepts a new level once it has been seen for T
// consecutive cycles (T = thresh_i, with 0 treated as 1). A per-pin bypass
// exposes the synchronised level directly while the filter keeps tracking.
// Optional feature macro: GPIO_IN_FILTER_EDGE_EN adds one-cycle rise/fall
// pulses that follow the visible output; without it rise_o/fall_o are 0.
module gpio_in_filter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  gpio_in_filter_if.slave bus
);

  // Effective threshold, one bit wider than the counter so that cnt+1 can
  // be compared without wrapping when thresh_i is at its maximum.
  logic [CNT_W:0] thresh_eff;
  // Visible per-pin level (bypass-selected), shared by the output and the
  // optional edge detector.
  logic [WIDTH-1:0] gpio_lvl;

  // Map a zero threshold onto one cycle so a stable sync level always wins
  always_comb begin
    thresh_eff = {1'b0, bus.thresh_i};
    if (bus.thresh_i == '0) begin
      thresh_eff = {{CNT_W{1'b0}}, 1'b1};
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_lvl;
    logic                   filt_reg;
    logic                   filt_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic [CNT_W:0]         cnt_inc;

    // Shift the raw pad level through the synchroniser chain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.pad_in_i[gi]};
      end
    end

    assign sync_lvl = sync_reg[SYNC_STAGES-1];

    // Counter is always below the effective threshold, so the widened
    // increment never overflows the comparison.
    assign cnt_inc = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};

    // Decide whether the current mismatch has lasted long enough to accept
    always_comb begin
      filt_next = filt_reg;
      cnt_next  = cnt_reg;
      if (sync_lvl == filt_reg) begin
        // Level agrees again: any pending glitch is abandoned
        cnt_next = '0;
      end else if (cnt_inc >= thresh_eff) begin
        // Mismatch has persisted for T cycles: accept the new level
        filt_next = sync_lvl;
        cnt_next  = '0;
      end else begin
        cnt_next = cnt_inc[CNT_W-1:0];
      end
    end

    // Commit filter level and stability counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        filt_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        filt_reg <= filt_next;
        cnt_reg  <= cnt_next;
      end
    end

    // Bypass only changes what is shown; the filter keeps running underneath
    assign gpio_lvl[gi] = bus.bypass_i[gi] ? sync_lvl : filt_reg;
  end

  assign bus.gpio_in_o = gpio_lvl;

`ifdef GPIO_IN_FILTER_EDGE_EN
  logic [WIDTH-1:0] prev_reg;

  // Remember last cycle's visible level so each output transition pulses once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= gpio_lvl;
    end
  end

  // Events track the visible output, including bypass-induced changes
  assign bus.rise_o = gpio_lvl & ~prev_reg;
  assign bus.fall_o = ~gpio_lvl & prev_reg;
`else
  assign bus.rise_o = '0;
  assign bus.fall_o = '0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed scenarios followed by a randomized phase, all
// compared every cycle against a history-based reference of the filter rule.
module tb_gpio_in_filter;
  localparam int W    = 16;
  localparam int SS   = 2;
  localparam int CW   = 8;
  localparam int MAXN = 4096;
`ifdef GPIO_IN_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  gpio_in_filter_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  gpio_in_filter #(
    .WIDTH      (W),
    .SYNC_STAGES(SS),
    .CNT_W      (CW)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: n counts clock edges since reset release. pad_hist[k] is the
  // pad value sampled at edge k; seen_hist[k] is the synchronised level the
  // filter looked at on edge k.
  int               n;
  logic [W-1:0]     pad_hist  [MAXN];
  logic [W-1:0]     seen_hist [MAXN];
  logic [W-1:0]     f_m;
  logic [W-1:0]     sync_m;
  logic [W-1:0]     prev_m;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    f_m    = '0;
    sync_m = '0;
    prev_m = '0;
  endtask

  // A pin takes its synchronised level once that level has differed from the
  // accepted one on the last T consecutive edges (T read at this edge).
  task automatic model_edge();
    int t;
    int streak;
    int k;
    n++;
    pad_hist[n]  = bus_if.pad_in_i;
    seen_hist[n] = sync_m;
    t = (bus_if.thresh_i == '0) ? 1 : int'(bus_if.thresh_i);
    for (int p = 0; p < W; p++) begin
      streak = 0;
      k      = n;
      while (k >= 1 && streak < t && seen_hist[k][p] != f_m[p]) begin
        streak++;
        k--;
      end
      if (streak >= t) f_m[p] = seen_hist[n][p];
    end
    sync_m = (n - SS + 1 >= 1) ? pad_hist[n - SS + 1] : '0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] g;
    logic [W-1:0] r;
    logic [W-1:0] fl;
    g  = (bus_if.bypass_i & sync_m) | (~bus_if.bypass_i & f_m);
    r  = EDGE_EN ? (g & ~prev_m) : '0;
    fl = EDGE_EN ? (~g & prev_m) : '0;
    chk("gpio_in", bus_if.gpio_in_o, g);
    chk("rise", bus_if.rise_o, r);
    chk("fall", bus_if.fall_o, fl);
    prev_m = rst_n ? g : '0;
  endtask

  // One cycle: check at the falling edge, advance on the rising edge, and
  // return 1 time unit later so the caller can set the next inputs.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  initial begin
    logic [W-1:0] tmp;
    int           pin;

    // ---- Reset with all pads high, then release with threshold 4
    model_reset();
    rst_n              = 1'b0;
    bus_if.pad_in_i    = 16'hFFFF;
    bus_if.thresh_i    = 8'd4;
    bus_if.bypass_i    = '0;
    #2;
    chk("rst_gpio", bus_if.gpio_in_o, 16'h0000);
    chk("rst_rise", bus_if.rise_o, 16'h0000);
    chk("rst_fall", bus_if.fall_o, 16'h0000);
    steps(3);
    rst_n = 1'b1;
    steps(5);
    chk("rel_e5_gpio", bus_if.gpio_in_o, 16'h0000);
    step();
    chk("rel_e6_gpio", bus_if.gpio_in_o, 16'hFFFF);
    chk("rel_e6_rise", bus_if.rise_o, EDGE_EN ? 16'hFFFF : 16'h0000);
    step();
    chk("rel_e7_rise", bus_if.rise_o, 16'h0000);
    chk("rel_e7_gpio", bus_if.gpio_in_o, 16'hFFFF);
    $display("scenario reset_release done checks=%0d", checks);

    // ---- Glitch reject / accept on pin 3 with threshold 5
    bus_if.pad_in_i = '0;
    bus_if.thresh_i = 8'd5;
    steps(10);
    bus_if.pad_in_i[3] = 1'b1;
    steps(4);
    bus_if.pad_in_i[3] = 1'b0;
    steps(10);
    chk("glitch4_gpio3", {15'b0, bus_if.gpio_in_o[3]}, 16'h0000);
    bus_if.pad_in_i[3] = 1'b1;
    steps(5);
    bus_if.pad_in_i[3] = 1'b0;
    step();
    chk("pulse5_e6_gpio3", {15'b0, bus_if.gpio_in_o[3]}, 16'h0000);
    step();
    chk("pulse5_e7_gpio3", {15'b0, bus_if.gpio_in_o[3]}, 16'h0001);
    chk("pulse5_e7_rise3", {15'b0, bus_if.rise_o[3]}, {15'b0, EDGE_EN});
    steps(4);
    chk("pulse5_e11_gpio3", {15'b0, bus_if.gpio_in_o[3]}, 16'h0001);
    step();
    chk("pulse5_e12_gpio3", {15'b0, bus_if.gpio_in_o[3]}, 16'h0000);
    chk("pulse5_e12_fall3", {15'b0, bus_if.fall_o[3]}, {15'b0, EDGE_EN});
    $display("scenario glitch_pin3 done checks=%0d", checks);

    // ---- Single-cycle pulse on pin 0 passes for threshold 0 and 1 alike
    for (int th = 0; th < 2; th++) begin
      bus_if.thresh_i    = 8'(th);
      steps(4);
      bus_if.pad_in_i[0] = 1'b1;
      step();
      bus_if.pad_in_i[0] = 1'b0;
      step();
      chk("short_e2_gpio0", {15'b0, bus_if.gpio_in_o[0]}, 16'h0000);
      step();
      chk("short_e3_gpio0", {15'b0, bus_if.gpio_in_o[0]}, 16'h0001);
      step();
      chk("short_e4_gpio0", {15'b0, bus_if.gpio_in_o[0]}, 16'h0000);
      $display("scenario short_pulse thresh=%0d done checks=%0d", th, checks);
    end

    // ---- Bypass on pin 7 with a long threshold
    bus_if.thresh_i    = 8'd200;
    bus_if.bypass_i[7] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      bus_if.pad_in_i[7] = (((i / 3) % 2) == 0);
      step();
    end
    bus_if.pad_in_i[7] = 1'b1;
    steps(6);
    chk("byp_gpio7_high", {15'b0, bus_if.gpio_in_o[7]}, 16'h0001);
    bus_if.bypass_i[7] = 1'b0;
    #1;
    chk("byp_clear_gpio7", {15'b0, bus_if.gpio_in_o[7]}, 16'h0000);
    chk("byp_clear_fall", bus_if.fall_o, EDGE_EN ? 16'h0080 : 16'h0000);
    steps(195);
    chk("byp_e201_gpio7", {15'b0, bus_if.gpio_in_o[7]}, 16'h0000);
    step();
    chk("byp_e202_gpio7", {15'b0, bus_if.gpio_in_o[7]}, 16'h0001);
    chk("byp_e202_rise7", {15'b0, bus_if.rise_o[7]}, {15'b0, EDGE_EN});
    $display("scenario bypass_pin7 done checks=%0d", checks);

    // ---- Threshold shrink while pin 2 is mid-count
    bus_if.thresh_i    = 8'd100;
    bus_if.pad_in_i[2] = 1'b1;
    steps(52);
    chk("shrink_before_gpio2", {15'b0, bus_if.gpio_in_o[2]}, 16'h0000);
    bus_if.thresh_i = 8'd10;
    step();
    chk("shrink_after_gpio2", {15'b0, bus_if.gpio_in_o[2]}, 16'h0001);
    $display("scenario thresh_shrink done checks=%0d", checks);

    // ---- Randomized phase with one asynchronous reset in the middle
    for (int i = 0; i < 320; i++) begin
      if (i % 40 == 0) bus_if.thresh_i = 8'($urandom_range(6));
      if (i % 50 == 25) bus_if.bypass_i = 16'($urandom);
      if ($urandom_range(3) == 0) begin
        pin = int'($urandom_range(W - 1));
        tmp = bus_if.pad_in_i;
        tmp[pin] = ~tmp[pin];
        bus_if.pad_in_i = tmp;
      end
      if (i == 160) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_gpio", bus_if.gpio_in_o, 16'h0000);
        chk("midrst_rise", bus_if.rise_o, 16'h0000);
        chk("midrst_fall", bus_if.fall_o, 16'h0000);
        model_reset();
        steps(2);
        rst_n = 1'b1;
      end
      step();
    end
    $display("scenario random done checks=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_in_filter.md
# gpio_in_filter

Per-pin input conditioning stage between the GPIO input pads and the SoC core's GPIO input bus. Takes the raw pad-to-core levels of the 16 GPIO pads, synchronises them into the system clock domain, rejects glitches shorter than a programmable number of cycles, and presents clean levels to the GPIO controller. Optionally generates single-cycle rise/fall event pulses for interrupt logic.

## Interface
- WIDTH, 16, number of GPIO pins handled.
- SYNC_STAGES, 2, synchroniser depth (legal 2..4).
- CNT_W, 8, width of per-pin stability counter and of the threshold input.

- clk_i  input  1  system clock.
- rst_n_i  input  1  reset; asynchronous assert, active-low.
- pad_in_i  input  WIDTH  raw pad input levels, asynchronous to clk_i.
- thresh_i  input  CNT_W  stability threshold in clk_i cycles; quasi-static config.
- bypass_i  input  WIDTH  per-pin filter bypass; 1 = output synchronised level directly.
- gpio_in_o  output  WIDTH  conditioned levels to GPIO controller.
- rise_o  output  WIDTH  one-cycle pulse per pin on 0->1 of gpio_in_o (macro-dependent).
- fall_o  output  WIDTH  one-cycle pulse per pin on 1->0 of gpio_in_o (macro-dependent).

## Operation
- Per pin, identical independent logic; no cross-pin interaction.
- Synchroniser: SYNC_STAGES flops in series; last stage is sync[i].
- Filter state per pin: filtered level f[i], counter cnt[i] (CNT_W bits).
- Effective threshold T = (thresh_i == 0) ? 1 : thresh_i.
- Each clk_i edge, per pin:
  - sync == f: cnt <= 0 (glitch abandoned).
  - sync != f and cnt+1 >= T: f <= sync, cnt <= 0.
  - sync != f and cnt+1 < T: cnt <= cnt+1.
- cnt never exceeds T-1, so no overflow; compare uses CNT_W+1 bits.
- gpio_in_o[i] = bypass_i[i] ? sync[i] : f[i]. Filter keeps running while bypassed.
- thresh_i changed mid-count: new T applies from next edge; if cnt+1 >= new T, f updates on next mismatching edge.
- Edge detect (when compiled in): prev[i] registers gpio_in_o[i]; rise_o = gpio_in_o & ~prev, fall_o = ~gpio_in_o & prev. Toggling bypass_i that changes gpio_in_o also produces a pulse (events follow visible output).
- Reset: all sync stages, f, cnt, prev cleared to 0; gpio_in_o = 0, rise_o = 0, fall_o = 0. No pulse emitted on reset release for pins held low; a pin held high emits exactly one rise once it propagates.
- Reset asserted mid-count: counters and f clear immediately; no pulse on the reset edge.

## Timing
- Pad change sampled at edge 1 appears on sync after SYNC_STAGES edges.
- Filtered path: gpio_in_o changes at edge SYNC_STAGES + T after first sampling edge, provided pad is stable throughout.
- Bypass path: gpio_in_o changes at edge SYNC_STAGES.
- Pulse shorter than T cycles at sync is fully rejected; pulse of exactly T cycles passes.
- rise_o/fall_o high for exactly one cycle, the first cycle gpio_in_o shows the new level.
- Throughput: one decision per pin per cycle, no stalls.

## Configuration
- Macro GPIO_IN_FILTER_EDGE_EN.
- Defined: prev flops and rise_o/fall_o logic present as above.
- Undefined: no prev flops; rise_o and fall_o tied to 0; gpio_in_o behaviour unchanged.

## Test plan
- Reset: hold rst_n_i=0, pad_in_i=16'hFFFF -> gpio_in_o=0, rise_o=0, fall_o=0; release, thresh_i=4 -> gpio_in_o=16'hFFFF at edge 6, rise_o=16'hFFFF for that one cycle only.
- Glitch reject: thresh_i=5, pin 3 high for 4 cycles then low -> gpio_in_o[3] stays 0, no rise_o[3]; high for 5 cycles -> gpio_in_o[3]=1 at edge 7, then fall follows 5 cycles after low.
- thresh_i=0 vs 1: single-cycle pad pulse on pin 0 -> passes in both cases, gpio_in_o[0]=1 at edge 3, identical timing.
- Bypass: bypass_i[7]=1, thresh_i=200, pin 7 toggles every 3 cycles -> gpio_in_o[7] follows with 2-cycle latency; clear bypass with f=0 while sync=1 -> fall_o[7] pulse, then rise after 200 stable cycles.
- Threshold shrink mid-count: thresh_i=100, pin 2 high for 50 cycles, set thresh_i=10 -> gpio_in_o[2]=1 on next edge.
- Macro off: repeat scenario 1 -> gpio_in_o identical, rise_o/fall_o constant 0.
